// File: rtl/marga_spi_pkg.sv
// Shared types and constants for the multi-channel OCRA SPI serialiser.
//   spi_state_t - serialiser FSM states
//   FRAME_CNT_W - width of the completed-frame counter
//   frame_len() - frame length in clk cycles for a given half-period H,
//                 word width and LDAC setting
package marga_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LDAC
    } spi_state_t;

    localparam int unsigned FRAME_CNT_W = 32;

    // SETUP (H) + SHIFT (2*H per bit) + HOLD (H), plus H for the LDAC pulse.
    function automatic int unsigned frame_len(input int unsigned h,
                                              input int unsigned word_w,
                                              input bit          ldac);
        return h * (2 * word_w + 2) + (ldac ? h : 32'd0);
    endfunction

endpackage

// File: rtl/ocra_spi_multi_if.sv
// Frame-request handshake between a frame producer and ocra_spi_multi.
//   valid   - frame request valid (producer)
//   ready   - serialiser can take a frame (serialiser)
//   data    - frame data, channel c at data[c*WORD_W +: WORD_W] (producer)
//   ldac_en - end this frame with an LDAC pulse (producer)
interface ocra_spi_multi_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned WORD_W = 24
);
    logic                     valid;
    logic                     ready;
    logic [N_CH*WORD_W-1:0]   data;
    logic                     ldac_en;

    modport master (output valid, data, ldac_en, input ready);
    modport slave  (input valid, data, ldac_en, output ready);
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period divider: counts 0..div_i and pulses tick_o on the last count.
//   clk, rst_n - clock, asynchronous active-low reset
//   restart_i  - hold the count at zero
//   div_i      - half-period minus one (H = div_i + 1)
//   tick_o     - high in the last cycle of every H-cycle window
module spi_tick_gen #(
    parameter int unsigned DIV_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q;

    assign tick_o = (cnt_q == div_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/ocra_spi_multi.sv
// N-channel SPI serialiser for gradient DAC boards.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clk_div_i   - SCLK half-period minus one, latched at frame start
//   bus         - frame request handshake (slave side)
//   abort_i     - drop the current and the pending frame
//   spi_clk_o   - shared SCLK, idles low
//   syncn_o     - shared frame sync, active low
//   ldacn_o     - shared DAC load, active low
//   sdo_o       - one serial data line per channel, MSB first
//   busy_o      - FSM not idle
//   frames_o    - completed-frame counter
module ocra_spi_multi
    import marga_spi_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned WORD_W = 24,
    parameter int unsigned DIV_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIV_W-1:0]       clk_div_i,
    ocra_spi_multi_if.slave        bus,
    input  logic                   abort_i,
    output logic                   spi_clk_o,
    output logic                   syncn_o,
    output logic                   ldacn_o,
    output logic [N_CH-1:0]        sdo_o,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frames_o
);
    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    spi_state_t             state_q;
    logic                   ready_q;
    logic [N_CH*WORD_W-1:0] pend_data_q;
    logic                   pend_ldac_q;
    logic [WORD_W-1:0]      shreg_q [N_CH];
    logic                   ldac_q;
    logic [DIV_W-1:0]       div_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic                   tick;
    logic                   frame_done;
    logic                   start_frame;

    // Every non-IDLE state exits on a tick, where the counter wraps to zero,
    // so holding the divider in IDLE restarts it on every state entry.
    spi_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (state_q == IDLE || abort_i),
        .div_i     (div_q),
        .tick_o    (tick)
    );

    // An empty buffer reads as ready, so !ready_q means a frame is pending.
    always_comb begin
        frame_done  = tick && ((state_q == HOLD && !ldac_q) || state_q == LDAC);
        start_frame = !ready_q && (state_q == IDLE || frame_done);
    end

    assign bus.ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            pend_data_q <= '0;
            pend_ldac_q <= 1'b0;
            ldac_q      <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            spi_clk_o   <= 1'b0;
            syncn_o     <= 1'b1;
            ldacn_o     <= 1'b1;
            sdo_o       <= '0;
            busy_o      <= 1'b0;
            frames_o    <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                shreg_q[c] <= '0;
            end
        end else if (abort_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            spi_clk_o <= 1'b0;
            syncn_o   <= 1'b1;
            ldacn_o   <= 1'b1;
            sdo_o     <= '0;
            busy_o    <= 1'b0;
        end else begin
            if (bus.valid && ready_q) begin
                pend_data_q <= bus.data;
                pend_ldac_q <= bus.ldac_en;
                ready_q     <= 1'b0;
            end

            if (start_frame) begin
                state_q   <= SETUP;
                ready_q   <= 1'b1;
                ldac_q    <= pend_ldac_q;
                div_q     <= clk_div_i;
                spi_clk_o <= 1'b0;
                syncn_o   <= 1'b0;
                ldacn_o   <= 1'b1;
                busy_o    <= 1'b1;
                // MSB goes straight out; the remaining bits wait in shreg_q.
                for (int c = 0; c < int'(N_CH); c++) begin
                    sdo_o[c]   <= pend_data_q[c*WORD_W + WORD_W - 1];
                    shreg_q[c] <= pend_data_q[c*WORD_W +: WORD_W] << 1;
                end
            end else begin
                unique case (state_q)
                    IDLE: ;
                    SETUP: begin
                        if (tick) begin
                            state_q   <= SHIFT;
                            spi_clk_o <= 1'b1;
                            bit_cnt_q <= BIT_W'(WORD_W - 1);
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (spi_clk_o) begin
                                spi_clk_o <= 1'b0;
                            end else if (bit_cnt_q == '0) begin
                                state_q <= HOLD;
                                syncn_o <= 1'b1;
                                sdo_o   <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 1'b1;
                                spi_clk_o <= 1'b1;
                                for (int c = 0; c < int'(N_CH); c++) begin
                                    sdo_o[c]   <= shreg_q[c][WORD_W-1];
                                    shreg_q[c] <= shreg_q[c] << 1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (ldac_q) begin
                                state_q <= LDAC;
                                ldacn_o <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                busy_o  <= 1'b0;
                            end
                        end
                    end
                    LDAC: begin
                        if (tick) begin
                            state_q <= IDLE;
                            ldacn_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (frame_done) begin
                frames_o <= frames_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ocra_spi_multi.sv
// Directed bench for ocra_spi_multi: frame timing, per-channel data, LDAC,
// back-to-back frames, abort, asynchronous reset and divider latching.
module tb_ocra_spi_multi;
    localparam int unsigned N_CH   = 4;
    localparam int unsigned WORD_W = 24;
    localparam int unsigned DIV_W  = 6;
    localparam int unsigned DW     = N_CH * WORD_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] clk_div_i;
    logic             abort_i;
    logic             spi_clk_o;
    logic             syncn_o;
    logic             ldacn_o;
    logic [N_CH-1:0]  sdo_o;
    logic             busy_o;
    logic [31:0]      frames_o;

    ocra_spi_multi_if #(.N_CH(N_CH), .WORD_W(WORD_W)) bus ();

    ocra_spi_multi #(
        .N_CH   (N_CH),
        .WORD_W (WORD_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_div_i (clk_div_i),
        .bus       (bus),
        .abort_i   (abort_i),
        .spi_clk_o (spi_clk_o),
        .syncn_o   (syncn_o),
        .ldacn_o   (ldacn_o),
        .sdo_o     (sdo_o),
        .busy_o    (busy_o),
        .frames_o  (frames_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    int n_busy, n_sync_lo, n_sync_hi, n_ldac_lo, n_rdy_lo, n_rise, n_fall;
    int hi_min, hi_max;
    logic [WORD_W-1:0] cap [N_CH];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until busy_o has risen and fallen again, sampling #1 after each
    // edge. Drops valid after n_acc acceptances, presenting next_data after
    // the first one; writes sw_div to clk_div_i at sample index sw_at.
    task automatic watch(input int budget, input int n_acc, input logic [DW-1:0] next_data,
                         input int sw_at, input logic [DIV_W-1:0] sw_div);
        int   acc;
        int   hi_run;
        bit   seen;
        bit   done;
        bit   fire;
        logic prev_clk;
        acc = 0; hi_run = 0; seen = 1'b0; done = 1'b0;
        n_busy = 0; n_sync_lo = 0; n_sync_hi = 0; n_ldac_lo = 0; n_rdy_lo = 0;
        n_rise = 0; n_fall = 0; hi_min = 1000; hi_max = 0;
        for (int c = 0; c < int'(N_CH); c++) cap[c] = '0;
        prev_clk = spi_clk_o;
        for (int i = 0; i < budget && !done; i++) begin
            fire = bus.valid && bus.ready;
            step();
            if (fire) begin
                acc++;
                if (acc >= n_acc) bus.valid = 1'b0;
                else bus.data = next_data;
            end
            if (i == sw_at) clk_div_i = sw_div;
            if (busy_o) begin
                seen = 1'b1;
                n_busy++;
                if (syncn_o) n_sync_hi++;
                else n_sync_lo++;
            end
            if (!ldacn_o) n_ldac_lo++;
            if (!bus.ready) n_rdy_lo++;
            if (spi_clk_o) begin
                if (!prev_clk) n_rise++;
                hi_run++;
            end else if (prev_clk) begin
                // Falling SCLK edge: this is where the DAC samples sdo.
                n_fall++;
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
                for (int c = 0; c < int'(N_CH); c++) cap[c] = {cap[c][WORD_W-2:0], sdo_o[c]};
            end
            prev_clk = spi_clk_o;
            if (seen && !busy_o) done = 1'b1;
        end
        if (!done) check_eq("watch_timeout", 0, 1);
    endtask

    initial begin
        int   rises;
        int   hi_cnt;
        int   busy_cnt;
        logic prev;

        rst_n = 1'b0; clk_div_i = '0; abort_i = 1'b0;
        bus.valid = 1'b0; bus.data = '0; bus.ldac_en = 1'b0;
        #12;
        check_eq("rst_sclk",   spi_clk_o, 0);
        check_eq("rst_syncn",  syncn_o,   1);
        check_eq("rst_ldacn",  ldacn_o,   1);
        check_eq("rst_sdo",    sdo_o,     0);
        check_eq("rst_ready",  bus.ready, 1);
        check_eq("rst_busy",   busy_o,    0);
        check_eq("rst_frames", frames_o,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // H=1 with LDAC: 51-cycle frame.
        clk_div_i = 6'd0; bus.ldac_en = 1'b1;
        bus.data = {24'h0, 24'h0, 24'h0, 24'hA5A5A5};
        bus.valid = 1'b1;
        watch(200, 1, '0, -1, '0);
        check_eq("t1_len",      n_busy,    51);
        check_eq("t1_sync_lo",  n_sync_lo, 49);
        check_eq("t1_ldac_lo",  n_ldac_lo, 1);
        check_eq("t1_falls",    n_fall,    24);
        check_eq("t1_word0",    cap[0],    24'hA5A5A5);
        check_eq("t1_word1",    cap[1],    24'h0);
        check_eq("t1_frames",   frames_o,  1);

        // H=4, no LDAC, four distinct words: 200-cycle frame.
        step();
        clk_div_i = 6'd3; bus.ldac_en = 1'b0;
        bus.data = {24'hC3A5F0, 24'h0F1E2D, 24'hABCDEF, 24'h123456};
        bus.valid = 1'b1;
        watch(400, 1, '0, -1, '0);
        check_eq("t2_len",      n_busy,    200);
        check_eq("t2_sync_lo",  n_sync_lo, 196);
        check_eq("t2_ldac_lo",  n_ldac_lo, 0);
        check_eq("t2_hi_min",   hi_min,    4);
        check_eq("t2_hi_max",   hi_max,    4);
        check_eq("t2_word0",    cap[0],    24'h123456);
        check_eq("t2_word1",    cap[1],    24'hABCDEF);
        check_eq("t2_word2",    cap[2],    24'h0F1E2D);
        check_eq("t2_word3",    cap[3],    24'hC3A5F0);
        check_eq("t2_frames",   frames_o,  2);

        // Back-to-back: second frame queues while the first shifts.
        step();
        clk_div_i = 6'd0; bus.ldac_en = 1'b0;
        bus.data = {24'h0, 24'h0, 24'h0, 24'h111111};
        bus.valid = 1'b1;
        watch(300, 2, {24'h0, 24'h0, 24'h000001, 24'h9C3E71}, -1, '0);
        check_eq("t3_busy",     n_busy,    100);
        check_eq("t3_sync_gap", n_sync_hi, 2);
        check_eq("t3_sync_lo",  n_sync_lo, 98);
        check_eq("t3_rdy_lo",   n_rdy_lo,  50);
        check_eq("t3_falls",    n_fall,    48);
        check_eq("t3_word0",    cap[0],    24'h9C3E71);
        check_eq("t3_word1",    cap[1],    24'h000001);
        check_eq("t3_frames",   frames_o,  4);

        // Abort at SHIFT bit 10 with a second frame pending.
        step();
        bus.data = {24'h0, 24'h0, 24'h0, 24'hFFFFFF};
        bus.valid = 1'b1;
        step();                          // accept first
        step();                          // SETUP, ready back up
        step();                          // accept second, SHIFT starts
        bus.valid = 1'b0;
        check_eq("t4_pending", bus.ready, 0);
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (spi_clk_o && !prev) rises++;
            prev = spi_clk_o;
            if (rises == 14) break;
            step();
        end
        check_eq("t4_reach_bit10", rises, 14);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("t4_syncn",  syncn_o,   1);
        check_eq("t4_sclk",   spi_clk_o, 0);
        check_eq("t4_ready",  bus.ready, 1);
        check_eq("t4_busy",   busy_o,    0);
        check_eq("t4_sdo",    sdo_o,     0);
        check_eq("t4_frames", frames_o,  4);
        // A request in the abort cycle is dropped.
        abort_i = 1'b1; bus.valid = 1'b1;
        step();
        abort_i = 1'b0; bus.valid = 1'b0;
        check_eq("t4_drop_ready", bus.ready, 1);
        hi_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (spi_clk_o) hi_cnt++;
            if (busy_o) busy_cnt++;
        end
        check_eq("t4_no_sclk", hi_cnt,   0);
        check_eq("t4_no_busy", busy_cnt, 0);
        check_eq("t4_frames2", frames_o, 4);

        // Asynchronous reset mid-SHIFT.
        bus.data = {24'h0, 24'h0, 24'h0, 24'hFFFFFF};
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        repeat (10) step();
        check_eq("t5_busy_pre", busy_o,   1);
        check_eq("t5_sdo_pre",  sdo_o[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_sclk",   spi_clk_o, 0);
        check_eq("t5_syncn",  syncn_o,   1);
        check_eq("t5_ldacn",  ldacn_o,   1);
        check_eq("t5_sdo",    sdo_o,     0);
        check_eq("t5_ready",  bus.ready, 1);
        check_eq("t5_busy",   busy_o,    0);
        check_eq("t5_frames", frames_o,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Divider changed mid-frame: only the next frame sees H=6.
        clk_div_i = 6'd0; bus.ldac_en = 1'b0;
        bus.data = {24'h0, 24'h00C0DE, 24'h0, 24'h3C3C3C};
        bus.valid = 1'b1;
        watch(200, 1, '0, 10, 6'd5);
        check_eq("t6a_len",    n_busy, 50);
        check_eq("t6a_hi_max", hi_max, 1);
        check_eq("t6a_word0",  cap[0], 24'h3C3C3C);
        check_eq("t6a_word2",  cap[2], 24'h00C0DE);
        step();
        bus.ldac_en = 1'b1;
        bus.data = {24'h0, 24'h0, 24'h0, 24'h5A0FF0};
        bus.valid = 1'b1;
        watch(500, 1, '0, -1, '0);
        check_eq("t6b_len",     n_busy,    306);
        check_eq("t6b_ldac_lo", n_ldac_lo, 6);
        check_eq("t6b_hi_min",  hi_min,    6);
        check_eq("t6b_hi_max",  hi_max,    6);
        check_eq("t6b_word0",   cap[0],    24'h5A0FF0);
        check_eq("t6b_frames",  frames_o,  2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ocra_spi_multi.md
Name: ocra_spi_multi

Overview:
- Parametrised N-channel SPI serialiser that drives gradient DAC boards from the marga_system core.
- Generalises the fixed 4-line OCRA1 output group (shared clk/syncn/ldacn, one sdo per axis) to N_CH data lines, configurable word width and runtime-configurable SCLK rate.
- Adds a one-deep pending buffer for back-to-back frames, optional LDAC pulse, synchronous abort and a completed-frame counter.

Parameters:
N_CH, 4, number of parallel SDO lines, one per DAC channel
WORD_W, 24, bits per channel per frame, sent MSB first
DIV_W, 6, width of the clock-divider setting

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
clk_div_i  in  DIV_W  half-period of SCLK in clk cycles, minus 1 (H = clk_div_i+1)
data_i  in  N_CH*WORD_W  frame data; channel c = data_i[c*WORD_W +: WORD_W]
ldac_en_i  in  1  when set, frame ends with an LDAC pulse
valid_i  in  1  frame-request valid
ready_o  out  1  pending buffer empty, frame can be accepted
abort_i  in  1  synchronous abort of current frame and pending frame
spi_clk_o  out  1  shared SCLK, idles low
syncn_o  out  1  shared frame sync, active low
ldacn_o  out  1  shared DAC load, active low
sdo_o  out  N_CH  serial data, one per channel
busy_o  out  1  high in any state other than IDLE
frames_o  out  32  count of completed frames, wraps at 2^32

Behaviour:
- Reset (async, rst_n low): spi_clk_o=0, syncn_o=1, ldacn_o=1, sdo_o=0, ready_o=1, busy_o=0, frames_o=0. Pending buffer cleared, FSM in IDLE. This applies mid-frame with no trailing edges.
- Handshake: the block accepts a transfer when valid_i&&ready_o at a clk edge. On acceptance it captures data_i and ldac_en_i into the pending buffer, and ready_o drops on the next cycle.
- A pending frame moves to the shift register when the FSM enters SETUP. At that point ready_o rises again on the next cycle, so one frame can queue while another shifts.
- clk_div_i is latched at SETUP entry. A change mid-frame has no effect until the next frame.
- Tick generator: the divider counts 0..H-1 and emits a tick on count H-1. It is restarted on every state entry.
- IDLE: outputs at reset values. When the pending buffer is full, the FSM goes to SETUP on the next cycle (1-cycle latency from acceptance).
- SETUP, H cycles: syncn_o=0, spi_clk_o=0, sdo_o[c]=MSB of channel c.
- SHIFT, WORD_W SCLK periods: each period is spi_clk_o high for H cycles, then low for H cycles.
  - sdo_o advances to the next bit in the same cycle spi_clk_o rises, for every bit after the first.
  - The DAC samples on falling edges.
  - The bit counter is WORD_W-1 down to 0.
- HOLD, H cycles: syncn_o=1, spi_clk_o=0, sdo_o=0.
- LDAC, H cycles, only if the latched ldac_en is set: ldacn_o=0, otherwise as HOLD.
- End of HOLD (no LDAC) or end of LDAC: frames_o increments. The FSM then goes to SETUP directly if the pending buffer is full (no IDLE cycle), else to IDLE.
- Frame length in clk cycles: H*(2*WORD_W+2), plus H with LDAC. Example: H=1, WORD_W=24, LDAC gives 51.
- abort_i has priority over everything except reset.
  - Next cycle: FSM in IDLE, pending cleared, outputs at idle values, ready_o=1.
  - frames_o does not increment.
  - A valid_i in the same cycle as abort_i is dropped.
- Simultaneous acceptance and SETUP entry from a full buffer cannot occur, because ready_o=0 while the buffer is full.
- Acceptance in the same cycle the buffer empties into SETUP is not possible, since ready_o is registered. A new frame is accepted one cycle later.
- All outputs are registered; no combinational path from inputs to outputs.
- clk_div_i=0 is legal: H=1, SCLK = clk/2.

Decomposition:
- Package marga_spi_pkg holds:
  - state enum spi_state_t {IDLE, SETUP, SHIFT, HOLD, LDAC}
  - FRAME_CNT_W=32
  - a function returning frame length for given H, WORD_W and ldac
- Sub-module spi_tick_gen (param DIV_W; ports clk, rst_n, restart_i, div_i, tick_o) implements the half-period divider.
- The top holds the FSM, pending buffer and N_CH shift registers.

Test Plan:
- Defaults, clk_div_i=0, ldac_en_i=1, channel 0 data=0xA5A5A5, others 0: syncn_o low for 49 cycles, ldacn_o low for 1 cycle, frame is 51 cycles. Sampling sdo_o[0] on 24 SCLK falling edges yields 0xA5A5A5. frames_o=1.
- clk_div_i=3, ldac_en_i=0, 4 distinct channel words: SCLK high/low 4 cycles each, frame 200 cycles, all 4 words decoded correctly, ldacn_o stays 1.
- Two frames with valid_i held high, H=1, no LDAC: second is accepted while the first shifts; syncn_o is high for exactly 1 cycle between frames; ready_o=0 while the buffer is full; frames_o=2.
- abort_i asserted at SHIFT bit 10 with a frame pending: next cycle syncn_o=1, spi_clk_o=0, ready_o=1, busy_o=0; frames_o unchanged; no further SCLK edges.
- rst_n low mid-SHIFT: outputs go to reset values asynchronously before the next clk edge; frames_o=0.
- clk_div_i changed from 0 to 5 during SHIFT: current frame completes at H=1, and the next frame runs at H=6.
